// File: rtl/apb_slave_regfile.sv
// APB slave register file: DEPTH x 32-bit word registers with a programmable
// number of access-phase wait states and fully registered responses.
// Optional feature macro: APB_SLVERR_EN (error response plus read-only ID
// register at index 0). With the macro undefined PSLVERR is tied low.
module apb_slave_regfile #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

`ifdef APB_SLVERR_EN
  localparam bit            SLVERR_EN = 1'b1;
  localparam logic [DW-1:0] ID_VALUE  = 32'hA5B0_0000 | DW'(DEPTH);
`else
  localparam bit            SLVERR_EN = 1'b0;
  localparam logic [DW-1:0] ID_VALUE  = '0;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   mem [DEPTH];

  logic [AW-1:0]   lat_idx;
  logic            lat_write;
  logic            lat_oor;
  logic [DW-1:0]   lat_wdata;

  logic            latch_en;
  logic            commit_en;
  logic            done_nxt;
  logic            pready_nxt;
  logic            pslverr_nxt;
  logic [DW-1:0]   prdata_nxt;

  logic [AW-1:0]   live_idx;
  logic            live_oor;
  logic [AW-1:0]   resp_idx;
  logic            resp_write;
  logic            resp_oor;
  logic            unused_addr_lsb;

  // Byte-lane bits carry no meaning for word registers
  assign unused_addr_lsb = ^PADDR[1:0];

  // Decode of the address currently on the bus
  assign live_idx = PADDR[AW+1:2];
  assign live_oor = |PADDR[DW-1:AW+2];

  // Response source: live bus when completing straight out of setup, else latched
  assign resp_idx   = latch_en ? live_idx : lat_idx;
  assign resp_write = latch_en ? PWRITE   : lat_write;
  assign resp_oor   = latch_en ? live_oor : lat_oor;

  // Next-state, counter and next-response logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    latch_en    = 1'b0;
    commit_en   = 1'b0;
    done_nxt    = 1'b0;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = '0;

    case (state)
      IDLE: begin
        if (PSELx && !PENABLE) begin
          latch_en  = 1'b1;
          cnt_nxt   = CW'(WAIT_STATES);
          state_nxt = ACCESS;
          done_nxt  = (CW'(WAIT_STATES) == '0);
        end
      end
      ACCESS: begin
        if (!PSELx) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (PENABLE) begin
          if (cnt != '0) begin
            cnt_nxt  = cnt - CW'(1);
            done_nxt = (cnt == CW'(1));
          end else begin
            commit_en = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          // Access phase not yet started: hold the pending response
          pready_nxt  = PREADY;
          pslverr_nxt = PSLVERR;
          prdata_nxt  = PRDATA;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (done_nxt) begin
      pready_nxt  = 1'b1;
      prdata_nxt  = (!resp_write && !resp_oor) ? mem[resp_idx] : '0;
      pslverr_nxt = SLVERR_EN && (resp_oor || (resp_write && (resp_idx == '0)));
    end
  end

  // State and wait counter
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture of the setup-phase transfer attributes
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_oor   <= 1'b0;
      lat_wdata <= '0;
    end else if (latch_en) begin
      lat_idx   <= live_idx;
      lat_write <= PWRITE;
      lat_oor   <= live_oor;
      lat_wdata <= PWDATA;
    end
  end

  // Register array; writes commit at the end of the completion cycle
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= (i == 0) ? ID_VALUE : '0;
      end
    end else if (commit_en && lat_write && !lat_oor &&
                 !(SLVERR_EN && (lat_idx == '0))) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

  // Registered APB response
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= pready_nxt;
      PSLVERR <= pslverr_nxt;
      PRDATA  <= prdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a WAIT_STATES=2 instance and a
// zero-wait instance share the APB bus, each with its own select.
module tb_apb_slave_regfile;

`ifdef APB_SLVERR_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  localparam logic [31:0] ID = 32'hA5B0_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel2 = 1'b0, psel0 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata2, prdata0;
  logic        pready2, pready0, pslverr2, pslverr0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(2)) dut (
    .PCLK(clk), .PRESET(rst), .PSELx(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
  );

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSELx(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  typedef struct {
    bit          use0;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
    if (SE) model[0] = ID;
  endtask

  // One complete transfer; returns at the falling edge inside the completion cycle
  task automatic xfer(input bit use0, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input bit exp_err, input string nm);
    int waits = 0;
    bit done = 1'b0;
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    psel2 = !use0; psel0 = use0;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      penable = 1'b1;
      pwdata  = ~wdata;
      if (use0 ? pready0 : pready2) done = 1'b1;
      else waits++;
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " waits"}, 32'(waits), use0 ? 32'd0 : 32'd2);
    chk({nm, " prdata"}, use0 ? prdata0 : prdata2, wr ? 32'd0 : exp_rd);
    chk({nm, " pslverr"}, 32'(use0 ? pslverr0 : pslverr2), 32'(exp_err));
    if (!use0 && wr && a[31:6] == '0 && !(SE && a[5:2] == '0)) model[a[5:2]] = wdata;
  endtask

  // Bus idle for one cycle; response must have dropped after completion
  task automatic idle(input bit use0, input string nm);
    @(negedge clk);
    psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
    chk({nm, " post pready"}, 32'(use0 ? pready0 : pready2), 32'd0);
    chk({nm, " post prdata"}, use0 ? prdata0 : prdata2, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h4,  32'd16,         32'd0,          1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h4,  32'd0,          32'd16,         1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h8,  32'hDEAD_BEEF,  32'd0,          1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h8,  32'd0,          32'hDEAD_BEEF,  1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h40, 32'h1234,       32'd0,          SE};
    vecs[5] = '{1'b0, 1'b0, 32'h40, 32'd0,          32'd0,          SE};
    vecs[6] = '{1'b0, 1'b1, 32'h3C, 32'hCAFE_F00D,  32'd0,          1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h3C, 32'd0,          32'hCAFE_F00D,  1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h7,  32'd0,          32'd16,         1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h8000_0004, 32'd0,   32'd0,          SE};
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset pready", 32'(pready2), 32'd0);
    chk("reset prdata", prdata2, 32'd0);
    chk("reset pslverr", 32'(pslverr2), 32'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].use0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
      idle(vecs[i].use0, $sformatf("vec%0d", i));
    end

    // All in-range registers against the model
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 1'b0, 32'(i * 4), 32'd0, model[i], 1'b0, $sformatf("sweep%0d", i));
      idle(1'b0, $sformatf("sweep%0d", i));
    end

    // Abort: select dropped in the first access cycle
    @(negedge clk);
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h77;
    @(negedge clk);
    psel2 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort pready c%0d", i), 32'(pready2), 32'd0);
      @(negedge clk);
    end
    xfer(1'b0, 1'b0, 32'hC, 32'd0, 32'd0, 1'b0, "abort readback");
    idle(1'b0, "abort readback");

    // Back-to-back writes with no idle cycle between them
    xfer(1'b0, 1'b1, 32'h0, 32'd1, 32'd0, SE, "b2b w0");
    xfer(1'b0, 1'b1, 32'h4, 32'd2, 32'd0, 1'b0, "b2b w1");
    idle(1'b0, "b2b");
    xfer(1'b0, 1'b0, 32'h0, 32'd0, SE ? ID : 32'd1, 1'b0, "b2b r0");
    xfer(1'b0, 1'b0, 32'h4, 32'd0, 32'd2, 1'b0, "b2b r1");
    idle(1'b0, "b2b r");

    // PENABLE high while idle is ignored
    @(negedge clk);
    psel2 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle-penable pready c%0d", i), 32'(pready2), 32'd0);
    end
    psel2 = 1'b0; penable = 1'b0;
    xfer(1'b0, 1'b0, 32'h4, 32'd0, 32'd2, 1'b0, "idle-penable readback");
    idle(1'b0, "idle-penable readback");

    // Reset asserted inside a read completion cycle clears outputs at once
    xfer(1'b0, 1'b1, 32'h4, 32'h55, 32'd0, 1'b0, "rst w");
    idle(1'b0, "rst w");
    xfer(1'b0, 1'b0, 32'h4, 32'd0, 32'h55, 1'b0, "rst r");
    rst = 1'b1;
    #1;
    chk("async rst pready", 32'(pready2), 32'd0);
    chk("async rst prdata", prdata2, 32'd0);
    @(negedge clk);
    rst = 1'b0; psel2 = 1'b0; penable = 1'b0;
    model_reset();

    // Reset during wait cycle 1 of an access
    xfer(1'b0, 1'b1, 32'h4, 32'h55, 32'd0, 1'b0, "rstw w");
    idle(1'b0, "rstw w");
    @(negedge clk);
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
    @(negedge clk);
    penable = 1'b1;
    chk("rstw wait1 pready", 32'(pready2), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstw pready", 32'(pready2), 32'd0);
    chk("rstw prdata", prdata2, 32'd0);
    @(negedge clk);
    rst = 1'b0; psel2 = 1'b0; penable = 1'b0;
    model_reset();
    xfer(1'b0, 1'b0, 32'h4, 32'd0, 32'd0, 1'b0, "rstw readback");
    idle(1'b0, "rstw readback");
    xfer(1'b0, 1'b0, 32'h0, 32'd0, model[0], 1'b0, "rstw idx0");
    idle(1'b0, "rstw idx0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB slave register file that sits directly downstream of the `apb` master block and consumes its `PSELx`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA` transfers.
- Returns `PRDATA`, `PREADY` and `PSLVERR` to the master.
- Holds `DEPTH` 32-bit word registers.
- Inserts a programmable number of wait states per transfer, so the master's PREADY-stall path is exercised with real timing.

Parameters:
- DEPTH, 16, number of 32-bit registers; power of 2, 2..256.
- WAIT_STATES, 2, number of access-phase cycles with `PREADY`=0 before completion; 0..15.
- AW, $clog2(DEPTH), register index width; derived, do not override.

Ports:
- PCLK  in  1  APB clock; all state updates on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSELx  in  1  slave select from master.
- PENABLE  in  1  access-phase indicator from master.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  byte address; `PADDR[1:0]` ignored, word index = `PADDR[AW+1:2]`.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only while `PREADY`=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; tied 0 when APB_SLVERR_EN is undefined.

Behaviour:
- Reset (PRESET=1, asynchronous, any state):
  - state=IDLE, wait counter=0;
  - all registers cleared to 32'h0;
  - `PREADY`=0, `PRDATA`=0, `PSLVERR`=0.
- FSM states:
  - IDLE: if `PSELx`=1 and `PENABLE`=0 (setup phase), latch `PADDR`, `PWRITE`, `PWDATA`, load counter=WAIT_STATES, go to ACCESS. Otherwise stay.
  - ACCESS:
    - If `PSELx`=0: abort to IDLE, no register update.
    - Else if `PENABLE`=1 and counter≠0: decrement, `PREADY`=0.
    - Else if `PENABLE`=1 and counter=0: `PREADY`=1 for exactly this cycle. Commit write on this edge, go to IDLE.
- Latency:
  - `PREADY` rises on the (WAIT_STATES+1)-th cycle of `PENABLE`=1.
  - With WAIT_STATES=0, `PREADY`=1 on the first access cycle.
- `PREADY`, `PRDATA` and `PSLVERR` are registered:
  - asserted on the edge that enters the completion cycle;
  - deasserted, and `PRDATA` returned to 0, on the following edge.
- Read: `PRDATA` = mem[latched index] during the `PREADY` cycle, 0 otherwise.
- Write: mem[latched index] <= latched `PWDATA` at the end of the `PREADY` cycle. `PWDATA` changes after setup are ignored.
- Out of range (`PADDR[31:2]` ≥ DEPTH):
  - write discarded;
  - read returns 32'h0;
  - `PSLVERR` per the optional feature.
- Back-to-back: IDLE accepts a new setup phase on the cycle immediately after completion. No dead cycle is required by the slave.
- `PENABLE`=1 while in IDLE (master protocol violation): ignored, stay IDLE, `PREADY`=0.

Optional Feature:
- APB_SLVERR_EN defined:
  - `PSLVERR`=1 coincident with `PREADY` for out-of-range address, or for a write to index 0, which is a read-only ID register.
  - Index 0 resets to 32'hA5B0_0000|DEPTH instead of 0.
- APB_SLVERR_EN undefined:
  - `PSLVERR` tied 0;
  - index 0 is an ordinary read/write register that resets to 0;
  - out-of-range handled silently as above.

Test Plan:
- Write then read, WAIT_STATES=2: write 32'd16 to `PADDR`=32'h4; `PREADY` stays 0 for 2 access cycles, rises on the 3rd. Read `PADDR`=32'h4 -> `PRDATA`=32'd16 in the `PREADY` cycle, 0 the next cycle.
- Zero-wait build (WAIT_STATES=0): write 32'hDEAD_BEEF to 32'h8, read back. `PREADY`=1 on the first `PENABLE` cycle each time; readback matches.
- Out-of-range, DEPTH=16: write 32'h1234 to 32'h40, then read 32'h40 -> `PRDATA`=0. All 16 in-range registers unchanged. `PSLVERR`=1 only with APB_SLVERR_EN.
- Abort: setup write to 32'hC, deassert `PSELx` in the 1st access cycle -> FSM IDLE, `PREADY` never asserted. Read 32'hC -> 0.
- Reset mid-access: assert PRESET during ACCESS wait cycle 1 after writing 32'h55 to 32'h4. Outputs go 0 immediately without a clock edge; after release, read 32'h4 -> 0.
- Back-to-back: write 32'd1 to 32'h0 then immediately write 32'd2 to 32'h4 with no idle cycle. Two `PREADY` pulses, both registers correct. With APB_SLVERR_EN, the index-0 write gives `PSLVERR`=1 and the ID value is retained.
